quad_step_gen: RTL and testbench

- Front-end stage that feeds the 4-bit up/down counter.
- Takes raw, asynchronous quadrature signals A/B from a rotary encoder, then synchronises, debounces and decodes them.
- Produces a single-cycle `step` pulse, which drives the counter's `en`, plus a direction level `up`, which drives the counter's `up`.
- Flags illegal Gray transitions on `err`.

---
 rtl/quad_pkg.sv | 26 ++
 rtl/quad_debounce.sv | 47 ++++
 rtl/quad_step_gen.sv | 104 ++++++++++
 tb/tb_quad_step_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and Gray-code constants for the quadrature step generator.
// The x4 decode option is selected elsewhere with the QUAD_X4_EN macro.
package quad_pkg;

    typedef enum logic {INIT, TRACK} quad_state_t;

    typedef logic [1:0] quad_ab_t;

    localparam quad_ab_t AB_00 = 2'b00;
    localparam quad_ab_t AB_01 = 2'b01;
    localparam quad_ab_t AB_11 = 2'b11;
    localparam quad_ab_t AB_10 = 2'b10;

    // Clockwise successor in the sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic quad_ab_t gray_next(input quad_ab_t ab);
        quad_ab_t nxt;
        case (ab)
            AB_00:   nxt = AB_01;
            AB_01:   nxt = AB_11;
            AB_11:   nxt = AB_10;
            default: nxt = AB_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: synchroniser chain followed by a debounce counter.
// While init is high the debounced value tracks the synchroniser output directly.
module quad_debounce
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic init,
    output logic clean
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q;
    logic                   clean_q;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign clean  = clean_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (init) begin
                clean_q <= sync_s;
                cnt_q   <= '0;
            end else if (sync_s == clean_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
                clean_q <= sync_s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/quad_step_gen.sv
// Quadrature front end: debounced A/B decoded into step/up pulses plus err on illegal moves.
// Define QUAD_X4_EN for a step on every legal transition; default emits one step per detent.
module quad_step_gen
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_in,
    input  logic b_in,
    output logic step,
    output logic up,
    output logic err
);

    localparam int unsigned InitW = $clog2(DEBOUNCE_CYCLES + 1);

    quad_state_t    state_q, state_d;
    logic [InitW-1:0] init_cnt_q;
    quad_ab_t       prev_q, cur;
    logic           clean_a, clean_b, in_init;
    logic           step_q, step_d, up_q, up_d, err_q, err_d;

    assign in_init = (state_q == INIT);
    assign cur     = {clean_a, clean_b};

    quad_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (a_in),
        .init (in_init),
        .clean(clean_a)
    );

    quad_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (b_in),
        .init (in_init),
        .clean(clean_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            prev_q     <= AB_00;
            step_q     <= 1'b0;
            up_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_init) begin
                init_cnt_q <= init_cnt_q + InitW'(1);
            end
            prev_q <= cur;
            step_q <= step_d;
            up_q   <= up_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_init && (init_cnt_q == InitW'(DEBOUNCE_CYCLES - 1))) begin
            state_d = TRACK;
        end
    end

    always_comb begin
        step_d = 1'b0;
        err_d  = 1'b0;
        up_d   = up_q;
        if (!in_init && (cur != prev_q)) begin
            if ((cur ^ prev_q) == 2'b11) begin
                err_d = 1'b1;
            end else begin
`ifdef QUAD_X4_EN
                step_d = 1'b1;
                up_d   = (gray_next(prev_q) == cur);
`else
                // Only the move that completes a detent (arrival at 00) counts.
                if (cur == AB_00) begin
                    step_d = 1'b1;
                    up_d   = (gray_next(prev_q) == cur);
                end
`endif
            end
        end
    end

    assign step = step_q;
    assign up   = up_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Directed bench for quad_step_gen with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expectations follow QUAD_X4_EN when that macro is defined.
module tb_quad_step_gen;
    import quad_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_in = 1'b0;
    logic b_in = 1'b0;
    logic step, up, err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_step = 0;
    int n_err = 0;
    int n_both = 0;
    int last_step_cyc = 0;
    logic last_up = 1'b0;

    quad_step_gen #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a_in (a_in),
        .b_in (b_in),
        .step (step),
        .up   (up),
        .err  (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step) begin
            n_step        <= n_step + 1;
            last_up       <= up;
            last_step_cyc <= cyc;
        end
        if (err) n_err <= n_err + 1;
        if (step && err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ab(input logic a, input logic b);
        @(posedge clk);
        #1;
        a_in = a;
        b_in = b;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    int s0, e0, t0;
`ifdef QUAD_X4_EN
    localparam int StepsPerDetent = 4;
`else
    localparam int StepsPerDetent = 1;
`endif

    initial begin
        // Reset and INIT baseline
        wait_cyc(3);
        @(negedge clk);
        check("rst_step", int'(step), 0);
        check("rst_up", int'(up), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        check("init_3cyc", int'(dut.state_q == TRACK), 0);
        wait_cyc(1);
        @(negedge clk);
        check("track_4cyc", int'(dut.state_q == TRACK), 1);
        wait_cyc(6);
        @(negedge clk);
        check("idle_steps", n_step, 0);
        check("idle_errs", n_err, 0);

        // CCW detent: (a,b) 00 -> 10 -> 11 -> 01 -> 00
        s0 = n_step; e0 = n_err;
        set_ab(1, 0); wait_cyc(9);
        set_ab(1, 1); wait_cyc(9);
        set_ab(0, 1); wait_cyc(9);
        set_ab(0, 0); t0 = cyc; wait_cyc(12);
        @(negedge clk);
        check("ccw_steps", n_step - s0, StepsPerDetent);
        check("ccw_up", int'(last_up), 0);
        check("ccw_errs", n_err - e0, 0);
        check("ccw_latency", last_step_cyc - t0, 8);

        // CW detent: (a,b) 00 -> 01 -> 11 -> 10 -> 00
        s0 = n_step; e0 = n_err;
        set_ab(0, 1); wait_cyc(9);
        set_ab(1, 1); wait_cyc(9);
        set_ab(1, 0); wait_cyc(9);
        set_ab(0, 0); t0 = cyc; wait_cyc(12);
        @(negedge clk);
        check("cw_steps", n_step - s0, StepsPerDetent);
        check("cw_up", int'(last_up), 1);
        check("cw_up_held", int'(up), 1);
        check("cw_latency", last_step_cyc - t0, 8);

        // Three-cycle glitch on A must be rejected
        s0 = n_step; e0 = n_err;
        set_ab(1, 0); wait_cyc(2);
        set_ab(0, 0); wait_cyc(15);
        @(negedge clk);
        check("glitch_steps", n_step - s0, 0);
        check("glitch_errs", n_err - e0, 0);

        // Illegal double change 00 -> 11
        s0 = n_step; e0 = n_err;
        set_ab(1, 1); wait_cyc(12);
        @(negedge clk);
        check("illegal_errs", n_err - e0, 1);
        check("illegal_steps", n_step - s0, 0);
        check("illegal_up", int'(up), 1);

        // One-cycle reset while sitting at 11
        s0 = n_step; e0 = n_err;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_step", int'(step), 0);
        check("midrst_up", int'(up), 0);
        check("midrst_err", int'(err), 0);
        rst_n = 1'b1;
        wait_cyc(15);
        @(negedge clk);
        check("rebase_errs", n_err - e0, 0);
        check("rebase_steps", n_step - s0, 0);
        check("rebase_ab", int'({dut.clean_a, dut.clean_b}), 3);
        check("never_both", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
